// File: rtl/pu_mem_rd_sched_pkg.sv
// Shared types and constants for the PU memory read scheduler.
package pu_mem_rd_sched_pkg;

  typedef enum logic [1:0] {
    SchedIdle,
    SchedRun,
    SchedStall,
    SchedDrain
  } sched_state_e;

  localparam int unsigned SchedStatNbits  = 32;
  localparam int unsigned SchedStallNbits = 16;

  localparam int unsigned DefNumOfPu         = 8;
  localparam int unsigned DefPuIdNbits       = 3;
  localparam int unsigned DefMaxOutstanding  = 4;

endpackage

// File: rtl/pu_mem_rd_sched_tag_fifo.sv
// In-order tag FIFO: remembers which PU owns each in-flight read.
// Depth must be a power of two so the pointers wrap naturally.
module pu_mem_rd_sched_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         din_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         dout_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/pu_mem_rd_sched.sv
// Round-robin read scheduler sharing one pipelined memory among NumOfPu requesters.
// Optional statistics counters are built when PU_MEM_RD_SCHED_STATS_EN is defined.
module pu_mem_rd_sched
  import pu_mem_rd_sched_pkg::*;
#(
  parameter int unsigned NumOfPu        = DefNumOfPu,
  parameter int unsigned PuIdNbits      = DefPuIdNbits,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic [NumOfPu-1:0]                req_i,
  output logic [NumOfPu-1:0]                gnt_ack_o,
  output logic                              gnt_valid_o,
  output logic [PuIdNbits-1:0]              gnt_sel_o,
  input  logic                              mem_ack_i,
  output logic [NumOfPu-1:0]                ret_ack_o,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              busy_o,
  output logic                              err_underflow_o,
  output logic [SchedStatNbits-1:0]         stat_gnt_cnt_o,
  output logic [SchedStallNbits-1:0]        stat_stall_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
  localparam logic [PuIdNbits-1:0] LastPu = PuIdNbits'(NumOfPu - 1);

  sched_state_e           state_q, state_d;
  logic [PuIdNbits-1:0]   ptr_q, ptr_d;
  logic [NumOfPu-1:0]     ret_ack_q, ret_ack_d;
  logic                   err_q, err_d;

  logic [PuIdNbits-1:0]   winner;
  logic                   found;
  logic                   grant_en;
  logic                   pop;
  logic [PuIdNbits-1:0]   fifo_head;
  logic [CntW-1:0]        fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  pu_mem_rd_sched_tag_fifo #(
    .Depth (MaxOutstanding),
    .Width (PuIdNbits)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_valid_o),
    .din_i   (gnt_sel_o),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Full blocks grants outright; a same-cycle pop only frees the slot for next cycle.
  assign grant_en = (state_q == SchedRun) && !fifo_full;
  assign pop      = mem_ack_i && !fifo_empty;

  // First set request at or after ptr_q, wrapping modulo NumOfPu.
  always_comb begin
    logic [PuIdNbits-1:0] cand;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumOfPu; i++) begin
      cand = PuIdNbits'((32'(ptr_q) + i) % NumOfPu);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_valid_o = grant_en && found;
    gnt_sel_o   = winner;
    gnt_ack_o   = '0;
    if (gnt_valid_o) gnt_ack_o[winner] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) ptr_d = (winner == LastPu) ? '0 : winner + 1'b1;
  end

  always_comb begin
    ret_ack_d = '0;
    if (pop) ret_ack_d[fifo_head] = 1'b1;
    err_d = err_q || (mem_ack_i && fifo_empty);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SchedIdle: begin
        if (en_i) state_d = SchedRun;
      end
      SchedRun: begin
        if (!en_i) begin
          state_d = fifo_empty ? SchedIdle : SchedDrain;
        end else if (fifo_full && !pop) begin
          state_d = SchedStall;
        end
      end
      SchedStall: begin
        if (pop) state_d = en_i ? SchedRun : SchedDrain;
      end
      SchedDrain: begin
        if (fifo_empty) begin
          state_d = SchedIdle;
        end else if (en_i) begin
          state_d = SchedRun;
        end
      end
      default: state_d = SchedIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SchedIdle;
      ptr_q     <= '0;
      ret_ack_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ret_ack_q <= ret_ack_d;
      err_q     <= err_d;
    end
  end

  assign ret_ack_o       = ret_ack_q;
  assign outstanding_o   = fifo_count;
  assign busy_o          = (state_q != SchedIdle);
  assign err_underflow_o = err_q;

`ifdef PU_MEM_RD_SCHED_STATS_EN
  logic [SchedStatNbits-1:0]  stat_gnt_cnt_q, stat_gnt_cnt_d;
  logic [SchedStallNbits-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_gnt_cnt_d = stat_gnt_cnt_q;
    stat_stall_d   = stat_stall_q;
    if (gnt_valid_o) stat_gnt_cnt_d = stat_gnt_cnt_q + 1'b1;
    // Stall counter saturates rather than wrapping.
    if ((state_q == SchedStall) && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_gnt_cnt_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_gnt_cnt_q <= stat_gnt_cnt_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_gnt_cnt_o = stat_gnt_cnt_q;
  assign stat_stall_o   = stat_stall_q;
`else
  assign stat_gnt_cnt_o = '0;
  assign stat_stall_o   = '0;
`endif

endmodule

// File: tb/tb_pu_mem_rd_sched.sv
// Table-driven bench for pu_mem_rd_sched with a tag scoreboard for ret_ack.
module tb_pu_mem_rd_sched;

  localparam int unsigned NPu = 8;
  localparam int unsigned IdW = 3;
  localparam int unsigned MaxOut = 4;
`ifdef PU_MEM_RD_SCHED_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           en = 1'b0;
  logic [NPu-1:0] req = '0;
  logic           mem_ack = 1'b0;
  logic [NPu-1:0] gnt_ack;
  logic           gnt_valid;
  logic [IdW-1:0] gnt_sel;
  logic [NPu-1:0] ret_ack;
  logic [2:0]     outstanding;
  logic           busy;
  logic           err_underflow;
  logic [31:0]    stat_gnt_cnt;
  logic [15:0]    stat_stall;

  always #5 clk = ~clk;

  pu_mem_rd_sched #(
    .NumOfPu        (NPu),
    .PuIdNbits      (IdW),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .en_i            (en),
    .req_i           (req),
    .gnt_ack_o       (gnt_ack),
    .gnt_valid_o     (gnt_valid),
    .gnt_sel_o       (gnt_sel),
    .mem_ack_i       (mem_ack),
    .ret_ack_o       (ret_ack),
    .outstanding_o   (outstanding),
    .busy_o          (busy),
    .err_underflow_o (err_underflow),
    .stat_gnt_cnt_o  (stat_gnt_cnt),
    .stat_stall_o    (stat_stall)
  );

  typedef struct {
    bit        rst;
    bit        en;
    bit [7:0]  req;
    bit        ack;
    bit        gv;
    bit [2:0]  sel;
    bit [2:0]  out;
    bit        busy;
    bit        err;
    bit        chk_stat;
    bit [31:0] sgnt;
    bit [15:0] sstall;
  } vec_t;

  vec_t        tbl[$];
  int unsigned sbq[$];
  logic [7:0]  pend_ret = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(bit rst, bit en_v, bit [7:0] req_v, bit ack, bit gv, int sel,
                              int out, bit busy_v, bit err_v);
    vec_t v;
    v.rst = rst; v.en = en_v; v.req = req_v; v.ack = ack; v.gv = gv;
    v.sel = 3'(sel); v.out = 3'(out); v.busy = busy_v; v.err = err_v;
    v.chk_stat = rst; v.sgnt = '0; v.sstall = '0;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic stat_last(int g, int s);
    tbl[tbl.size()-1].chk_stat = 1'b1;
    tbl[tbl.size()-1].sgnt     = StatsEn ? 32'(g) : 32'd0;
    tbl[tbl.size()-1].sstall   = StatsEn ? 16'(s) : 16'd0;
  endtask

  task automatic run_row(vec_t v, int row);
    logic [7:0] exp_ack;
    logic [7:0] exp_ret;
    @(posedge clk);
    #1;
    rst_ni  = !v.rst;
    en      = v.en;
    req     = v.req;
    mem_ack = v.ack;
    @(negedge clk);
    exp_ret = v.rst ? 8'h00 : pend_ret;
    exp_ack = v.gv ? (8'h01 << v.sel) : 8'h00;
    chk("gnt_valid", row, 32'(gnt_valid), 32'(v.gv));
    if (v.gv) chk("gnt_sel", row, 32'(gnt_sel), 32'(v.sel));
    chk("gnt_ack", row, 32'(gnt_ack), 32'(exp_ack));
    chk("outstanding", row, 32'(outstanding), 32'(v.out));
    chk("busy", row, 32'(busy), 32'(v.busy));
    chk("err_underflow", row, 32'(err_underflow), 32'(v.err));
    chk("ret_ack", row, 32'(ret_ack), 32'(exp_ret));
    if (v.chk_stat) begin
      chk("stat_gnt_cnt", row, stat_gnt_cnt, v.sgnt);
      chk("stat_stall", row, 32'(stat_stall), 32'(v.sstall));
    end
    // Scoreboard: pop the owner of the acked read before pushing this cycle's grant.
    pend_ret = '0;
    if (v.rst) begin
      sbq.delete();
    end else begin
      if (v.ack && sbq.size() > 0) pend_ret = 8'h01 << sbq.pop_front();
      if (v.gv) sbq.push_back(int'(v.sel));
    end
  endtask

  initial begin
    bit got;
    //                 rst en req   ack gv sel out busy err
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    // alternating requesters 0 and 2
    tbl.push_back(mk(0, 1, 8'h05, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h05, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h05, 1, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h05, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h05, 1, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    // all requesting: fill credits, stall, release
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 2, 2, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 3, 3, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 4, 3, 1, 0));
    // full with ack and req together: no grant until next cycle
    tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 5, 3, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 4, 1, 0));
    // en dropped with reads in flight: drain
    tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 0, 0, 0));
    stat_last(6, 3);
    // underflow is sticky
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h80, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h80, 0, 1, 7, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8'h81, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 8'h03, 0, 1, 1, 2, 1, 1));
    tbl.push_back(mk(0, 1, 8'h04, 0, 1, 2, 3, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 4, 1, 1));
    stat_last(10, 3);
    // reset with reads in flight clears everything
    tbl.push_back(mk(1, 1, 8'hFF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 1, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    // Reset asserted between clock edges must clear outputs without waiting for a clock.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_gnt_valid", -1, 32'(gnt_valid), 32'd0);
    chk("async_rst_outstanding", -1, 32'(outstanding), 32'd0);
    chk("async_rst_busy", -1, 32'(busy), 32'd0);
    chk("async_rst_stat_gnt", -1, stat_gnt_cnt, 32'd0);

    // After reset the pointer is back at 0, so a lone request from PU4 wins on first grant.
    @(posedge clk);
    #1;
    rst_ni  = 1'b1;
    en      = 1'b1;
    req     = 8'h10;
    mem_ack = 1'b0;
    got     = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (gnt_valid) got = 1'b1;
    end
    chk("first_grant_seen", -1, 32'(got), 32'd1);
    if (got) begin
      chk("first_grant_sel", -1, 32'(gnt_sel), 32'd4);
      chk("first_grant_ack", -1, 32'(gnt_ack), 32'h10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
